// File: rtl/sys_defs.sv
// Shared type definitions for the front end: instruction word, fetch/decode
// control bundle, fetch-queue entry and fetch-queue FSM states.
package sys_defs;

    typedef logic [31:0] INSTRUCTION;

    typedef struct packed {
        logic halt;
        logic cond_branch;
        logic uncond_branch;
        logic branch;
        logic wr_mem;
    } FD_control_t;

    typedef struct packed {
        INSTRUCTION  inst;
        logic [63:0] pc;
        logic [63:0] npc;
        FD_control_t fd_control;
    } FQ_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fq_state_t;

    localparam INSTRUCTION PAL_HALT = 32'h0000_0555;

    // Number of valid ways in a 2-way valid vector; way1 only counts behind way0.
    function automatic logic [1:0] way_count(input logic [1:0] valid);
        logic [1:0] n;
        if (valid[0]) begin
            n = valid[1] ? 2'd2 : 2'd1;
        end else begin
            n = 2'd0;
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle between fetch, the fetch queue and dispatch. The master side is the
// surrounding pipeline (fetch + dispatch), the slave side is the queue.
interface fetch_queue_if
    import sys_defs::*;
#(
    parameter int FQ_DEPTH = 8
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic        [1:0]       if_valid;
    INSTRUCTION  [1:0]       if_inst;
    logic        [1:0][63:0] if_pc;
    logic        [1:0][63:0] if_npc;
    FD_control_t [1:0]       if_fd_control;
    logic        [1:0]       ds_accept;
    logic                    flush;

    logic        [1:0]       fq_free_slots;
    logic        [1:0]       fq_out_valid;
    INSTRUCTION  [1:0]       fq_out_inst;
    logic        [1:0][63:0] fq_out_pc;
    logic        [1:0][63:0] fq_out_npc;
    FD_control_t [1:0]       fq_out_fd_control;
    logic                    fq_halted;
    logic        [CW-1:0]    fq_count;

    modport master (
        output if_valid, if_inst, if_pc, if_npc, if_fd_control, ds_accept, flush,
        input  fq_free_slots, fq_out_valid, fq_out_inst, fq_out_pc, fq_out_npc,
               fq_out_fd_control, fq_halted, fq_count
    );

    modport slave (
        input  if_valid, if_inst, if_pc, if_npc, if_fd_control, ds_accept, flush,
        output fq_free_slots, fq_out_valid, fq_out_inst, fq_out_pc, fq_out_npc,
               fq_out_fd_control, fq_halted, fq_count
    );

endinterface

// File: rtl/fetch_queue_chk.sv
// Protocol checker for the fetch queue handshake. Dispatch must never take
// more entries than are shown valid; fetch must keep way1 behind way0 and,
// when CHECK_FETCH_OVERFLOW is set, never offer more ways than free slots.
module fetch_queue_chk
    import sys_defs::*;
#(
    parameter bit CHECK_FETCH_OVERFLOW = 1'b1
) (
    input logic       clock,
    input logic       reset_n,
    input logic [1:0] if_valid,
    input logic [1:0] ds_accept,
    input logic [1:0] fq_out_valid,
    input logic [1:0] fq_free_slots
);
    logic [1:0] out_n_s;
    logic [1:0] fetch_n_s;

    // Entry counts implied by the valid vectors.
    always_comb begin
        out_n_s   = way_count(fq_out_valid);
        fetch_n_s = way_count(if_valid);
    end

    a_ds_accept_le_valid: assert property (
        @(posedge clock) disable iff (!reset_n) ds_accept <= out_n_s);

    a_way1_needs_way0: assert property (
        @(posedge clock) disable iff (!reset_n) if_valid[1] |-> if_valid[0]);

    generate
        if (CHECK_FETCH_OVERFLOW) begin : g_fetch_overflow
            a_fetch_le_free: assert property (
                @(posedge clock) disable iff (!reset_n) fetch_n_s <= fq_free_slots);
        end
    endgenerate

endmodule

// File: rtl/fetch_queue.sv
// Two-wide in, two-wide out circular fetch queue between fetch and dispatch.
// Accepting a halt instruction stops further enqueue until a flush; every
// output is derived from registered state only.
module fetch_queue
    import sys_defs::*;
#(
    parameter int FQ_DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_queue_if.slave  fq
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    FQ_entry_t     mem_q [FQ_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] head_p1_s, tail_p1_s;
    logic [CW-1:0] count_q, count_d, free_ent_s;
    fq_state_t     state_q, state_d;
    logic [1:0]    free_slots_s, nreq_s, nenq_s, ndeq_s, acc_s, avail_s;
    logic          halt_enq_s, wr0_s, wr1_s;
    FQ_entry_t     way_s [2];

    assign head_p1_s = head_q + PW'(1);
    assign tail_p1_s = tail_q + PW'(1);

    // Free-slot offer to fetch, from the current count and state only.
    always_comb begin
        free_ent_s = CW'(FQ_DEPTH) - count_q;
        if (state_q == HALTED) begin
            free_slots_s = 2'd0;
        end else if (free_ent_s >= CW'(2)) begin
            free_slots_s = 2'd2;
        end else begin
            free_slots_s = free_ent_s[1:0];
        end
    end

    // Clamp enqueue/dequeue amounts; a halt in way0 squashes the younger way.
    always_comb begin
        nreq_s = way_count(fq.if_valid);
        if (nreq_s == 2'd2 && fq.if_fd_control[0].halt) begin
            nreq_s = 2'd1;
        end else begin
            nreq_s = nreq_s;
        end
        nenq_s  = (nreq_s > free_slots_s) ? free_slots_s : nreq_s;
        acc_s   = (fq.ds_accept == 2'd3) ? 2'd2 : fq.ds_accept;
        avail_s = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        ndeq_s  = (acc_s > avail_s) ? avail_s : acc_s;
        halt_enq_s = ((nenq_s != 2'd0) && fq.if_fd_control[0].halt) ||
                     ((nenq_s == 2'd2) && fq.if_fd_control[1].halt);
        wr0_s = !fq.flush && (nenq_s != 2'd0);
        wr1_s = !fq.flush && (nenq_s == 2'd2);
        for (int w = 0; w < 2; w++) begin
            way_s[w].inst       = fq.if_inst[w];
            way_s[w].pc         = fq.if_pc[w];
            way_s[w].npc        = fq.if_npc[w];
            way_s[w].fd_control = fq.if_fd_control[w];
        end
    end

    // Next pointers, count and RUN/HALTED state; flush overrides everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (fq.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = RUN;
        end else begin
            head_d  = head_q + PW'(ndeq_s);
            tail_d  = tail_q + PW'(nenq_s);
            count_d = count_q + CW'(nenq_s) - CW'(ndeq_s);
            case (state_q)
                RUN:     state_d = halt_enq_s ? HALTED : RUN;
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Entry storage; deliberately not reset, validity comes from count.
    always_ff @(posedge clock) begin
        if (wr0_s) mem_q[tail_q]    <= way_s[0];
        if (wr1_s) mem_q[tail_p1_s] <= way_s[1];
    end

    assign fq.fq_free_slots        = free_slots_s;
    assign fq.fq_out_valid         = {count_q >= CW'(2), count_q != CW'(0)};
    assign fq.fq_halted            = (state_q == HALTED);
    assign fq.fq_count             = count_q;
    assign fq.fq_out_inst[0]       = mem_q[head_q].inst;
    assign fq.fq_out_inst[1]       = mem_q[head_p1_s].inst;
    assign fq.fq_out_pc[0]         = mem_q[head_q].pc;
    assign fq.fq_out_pc[1]         = mem_q[head_p1_s].pc;
    assign fq.fq_out_npc[0]        = mem_q[head_q].npc;
    assign fq.fq_out_npc[1]        = mem_q[head_p1_s].npc;
    assign fq.fq_out_fd_control[0] = mem_q[head_q].fd_control;
    assign fq.fq_out_fd_control[1] = mem_q[head_p1_s].fd_control;

endmodule
